branch_unit_stack: RTL and testbench

Parametrised program-counter/branch unit: the next generation of the datapath sequencer's branch control. It computes the next PC each enabled cycle from absolute jumps, sign-extended relative branches on four selectable flags, and subroutine call/return through an internal return-address stack. It sits between the instruction decoder (PL, JB, BC, CALL, RET, AD, Bas_A) and the instruction memory address input (PC).

---
 rtl/branch_unit_stack.sv | 120 ++++++++++++
 tb/tb_branch_unit_stack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit_stack.sv
// Program-counter / branch unit: absolute jumps, flag-conditional relative branches,
// and subroutine call/return through a small internal LIFO of return addresses.
module branch_unit_stack #(
  parameter int PC_W      = 8,
  parameter int OFF_W     = 6,
  parameter int STK_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             PL,
  input  logic             JB,
  input  logic [1:0]       BC,
  input  logic             Z,
  input  logic             N,
  input  logic             C,
  input  logic             V,
  input  logic [OFF_W-1:0] AD,
  input  logic [PC_W-1:0]  Bas_A,
  input  logic             CALL,
  input  logic             RET,
  input  logic             clr_err,
  output logic [PC_W-1:0]  PC,
  output logic             taken,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int SP_W  = $clog2(STK_DEPTH + 1);
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [PC_W-1:0]  stack [STK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] topIdx;
  logic [IDX_W-1:0] pushIdx;
  logic [PC_W-1:0]  pcInc;
  logic [PC_W-1:0]  adExt;
  logic [PC_W-1:0]  nextPc;
  logic             nextTaken;
  logic             flagSel;
  logic             doPush;
  logic             doPop;
  logic             setErr;

  assign pcInc     = PC + PC_W'(1);
  assign adExt     = PC_W'($signed(AD));
  assign stk_full  = (sp == SP_W'(STK_DEPTH));
  assign stk_empty = (sp == '0);
  assign topIdx    = IDX_W'(sp - SP_W'(1));
  assign pushIdx   = IDX_W'(sp);

  // RET outranks CALL, so a simultaneous CALL neither pushes nor flags an error.
  assign doPop  = en & RET & ~stk_empty;
  assign doPush = en & ~RET & CALL & ~stk_full;
  assign setErr = en & ((RET & stk_empty) | (~RET & CALL & stk_full));

  always_comb begin
    flagSel = 1'b0;
    case (BC)
      2'b00:   flagSel = Z;
      2'b01:   flagSel = N;
      2'b10:   flagSel = C;
      default: flagSel = V;
    endcase
  end

  always_comb begin
    nextPc    = pcInc;
    nextTaken = 1'b0;
    if (RET) begin
      if (!stk_empty) begin
        nextPc    = stack[topIdx];
        nextTaken = 1'b1;
      end
    end else if (CALL) begin
      if (!stk_full) begin
        nextPc    = Bas_A;
        nextTaken = 1'b1;
      end
    end else if (PL && JB) begin
      nextPc    = Bas_A;
      nextTaken = 1'b1;
    end else if (PL && flagSel) begin
      // Offset is relative to the current PC, not PC+1; wrap is silent.
      nextPc    = PC + adExt;
      nextTaken = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC      <= PC_W'(RESET_PC);
      taken   <= 1'b0;
      sp      <= '0;
      stk_err <= 1'b0;
    end else begin
      if (en) begin
        PC    <= nextPc;
        taken <= nextTaken;
        if (doPush)
          sp <= sp + SP_W'(1);
        else if (doPop)
          sp <= sp - SP_W'(1);
      end
      if (setErr)
        stk_err <= 1'b1;
      else if (clr_err)
        stk_err <= 1'b0;
    end
  end

  // Contents need no reset: the pointer alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (doPush)
      stack[pushIdx] <= pcInc;
  end

endmodule

// File: tb/tb_branch_unit_stack.sv
// Bench for branch_unit_stack: directed scenarios then random traffic, each cycle
// compared against a queue-based behavioural model of the branch unit.
module tb_branch_unit_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, PL, JB, Z, N, C, V, CALL, RET, clr_err;
  logic [1:0] BC;
  logic [5:0] AD;
  logic [7:0] Bas_A;
  logic [7:0] PC;
  logic       taken, stk_full, stk_empty, stk_err;

  int n_checks = 0;
  int n_errors = 0;

  int m_pc;
  int m_taken;
  int m_err;
  int m_stk[$];

  always #5 clk = ~clk;

  branch_unit_stack #(.PC_W(8), .OFF_W(6), .STK_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .PL(PL), .JB(JB), .BC(BC),
    .Z(Z), .N(N), .C(C), .V(V), .AD(AD), .Bas_A(Bas_A),
    .CALL(CALL), .RET(RET), .clr_err(clr_err),
    .PC(PC), .taken(taken), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic idle();
    en = 1'b1; PL = 0; JB = 0; BC = 0; Z = 0; N = 0; C = 0; V = 0;
    AD = 0; Bas_A = 0; CALL = 0; RET = 0; clr_err = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_taken = 0; m_err = 0;
    m_stk.delete();
  endtask

  function automatic int flag_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return int'(Z);
      2'b01:   return int'(N);
      2'b10:   return int'(C);
      default: return int'(V);
    endcase
  endfunction

  // Behavioural next-state from the priority list, plain integer arithmetic mod 256.
  task automatic model_step();
    int off;
    bit fail;
    fail = 0;
    if (en) begin
      m_taken = 0;
      if (RET) begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_back(); m_taken = 1;
        end else begin
          m_pc = (m_pc + 1) % 256; fail = 1;
        end
      end else if (CALL) begin
        if (m_stk.size() < 4) begin
          m_stk.push_back((m_pc + 1) % 256); m_pc = int'(Bas_A); m_taken = 1;
        end else begin
          m_pc = (m_pc + 1) % 256; fail = 1;
        end
      end else if (PL && JB) begin
        m_pc = int'(Bas_A); m_taken = 1;
      end else if (PL && flag_of(BC) == 1) begin
        off = (int'(AD) >= 32) ? int'(AD) - 64 : int'(AD);
        m_pc = (m_pc + off + 256) % 256; m_taken = 1;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
    if (fail) m_err = 1;
    else if (clr_err) m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pc"},    int'(PC),        m_pc);
    check_val({tag, ".taken"}, int'(taken),     m_taken);
    check_val({tag, ".full"},  int'(stk_full),  (m_stk.size() == 4) ? 1 : 0);
    check_val({tag, ".empty"}, int'(stk_empty), (m_stk.size() == 0) ? 1 : 0);
    check_val({tag, ".err"},   int'(stk_err),   m_err);
  endtask

  // Inputs are set away from the edge; outputs are sampled 1ns after it.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic jump_to(input logic [7:0] a);
    idle(); PL = 1; JB = 1; Bas_A = a;
    cycle("jump");
  endtask

  initial begin
    rst = 1'b1;
    idle(); en = 0;
    model_reset();
    #1;
    check_all("reset");
    #20;
    rst = 1'b0;

    idle();
    for (int i = 1; i <= 3; i++) begin
      cycle("seq");
      check_val("seq.const", int'(PC), i);
    end

    jump_to(8'h10);
    idle(); PL = 1; BC = 2'b01; N = 1; AD = 6'b111100;
    cycle("br_n_taken");
    check_val("br_n_taken.const", int'(PC), 8'h0C);
    jump_to(8'h10);
    idle(); PL = 1; BC = 2'b01; N = 0; AD = 6'b111100;
    cycle("br_n_not");
    check_val("br_n_not.const", int'(PC), 8'h11);
    jump_to(8'h10);
    idle(); PL = 1; BC = 2'b10; C = 1; AD = 6'h1F;
    cycle("br_c");
    check_val("br_c.const", int'(PC), 8'h2F);

    jump_to(8'hFE);
    idle(); PL = 1; BC = 2'b00; Z = 1; AD = 6'h05;
    cycle("wrap_br");
    check_val("wrap_br.const", int'(PC), 8'h03);
    jump_to(8'hFF);
    idle();
    cycle("wrap_inc");
    check_val("wrap_inc.const", int'(PC), 8'h00);

    jump_to(8'h10);
    idle(); CALL = 1; Bas_A = 8'h40; cycle("call1");
    check_val("call1.const", int'(PC), 8'h40);
    idle(); cycle("call_gap");
    idle(); CALL = 1; Bas_A = 8'h80; PL = 1; JB = 1; cycle("call2");
    check_val("call2.const", int'(PC), 8'h80);
    idle(); RET = 1; CALL = 1; Bas_A = 8'h33; cycle("ret1");
    check_val("ret1.const", int'(PC), 8'h42);
    idle(); RET = 1; cycle("ret2");
    check_val("ret2.const", int'(PC), 8'h11);
    check_val("ret2.empty", int'(stk_empty), 1);

    for (int i = 0; i < 4; i++) begin
      idle(); CALL = 1; Bas_A = 8'(8'h20 * i + 8'h05); cycle("fill");
    end
    check_val("fill.full", int'(stk_full), 1);
    idle(); CALL = 1; Bas_A = 8'h99; cycle("overflow");
    check_val("overflow.err", int'(stk_err), 1);
    for (int i = 0; i < 4; i++) begin
      idle(); RET = 1; cycle("drain");
    end
    idle(); RET = 1; clr_err = 1; cycle("underflow");
    check_val("underflow.err", int'(stk_err), 1);
    idle(); en = 0; clr_err = 1; cycle("clr_noen");
    check_val("clr_noen.err", int'(stk_err), 0);

    idle(); CALL = 1; Bas_A = 8'h50; cycle("depth1");
    idle(); CALL = 1; Bas_A = 8'h60; cycle("depth2");
    for (int i = 0; i < 3; i++) begin
      idle(); en = 0; RET = 1; cycle("stall");
    end
    check_val("stall.pc", int'(PC), 8'h60);

    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    check_val("async_rst.clk_low", int'(clk), 0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      idle();
      en      = ($urandom_range(0, 9) < 8);
      PL      = ($urandom_range(0, 9) < 4);
      JB      = 1'($urandom);
      BC      = 2'($urandom);
      {Z, N, C, V} = 4'($urandom);
      AD      = 6'($urandom);
      Bas_A   = 8'($urandom);
      CALL    = ($urandom_range(0, 99) < 18);
      RET     = ($urandom_range(0, 99) < 15);
      clr_err = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
